// File: rtl/clk_div_bank.sv
// Bank of independently programmable clock dividers. Divisor updates land only on a
// period boundary, and a global sync strobe realigns every channel's phase.
module clk_div_bank #(
   parameter int unsigned CHANNELS = 8,
   parameter int unsigned CNT_W    = 28,
   parameter int unsigned AW       = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_we,
   input  logic [AW-1:0]       cfg_addr,
   input  logic [CNT_W-1:0]    cfg_div,
   input  logic [CHANNELS-1:0] en,
   input  logic                sync,
   output logic [CHANNELS-1:0] cout,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] cfg_pend
);

   localparam int unsigned CAP_SH = CNT_W - 1;

   // Power-on divisor: /2, /4, /8 ... saturating at 2^(CNT_W-1).
   function automatic logic [CNT_W-1:0] rst_div(input int unsigned idx);
      if (idx + 1 >= CAP_SH) return CNT_W'(1) << CAP_SH;
      return CNT_W'(1) << (idx + 1);
   endfunction

   logic [CNT_W-1:0]    cnt_q  [CHANNELS];
   logic [CNT_W-1:0]    cnt_d  [CHANNELS];
   logic [CNT_W-1:0]    div_q  [CHANNELS];
   logic [CNT_W-1:0]    div_d  [CHANNELS];
   logic [CNT_W-1:0]    pdiv_q [CHANNELS];
   logic [CNT_W-1:0]    pdiv_d [CHANNELS];
   logic [CHANNELS-1:0] pf_q, pf_d;
   logic [CHANNELS-1:0] cout_q, cout_d;
   logic [CHANNELS-1:0] tick_q, tick_d;
   logic [CHANNELS-1:0] wr_c;
   logic [CNT_W-1:0]    wdiv_c;

   // Values 0 and 1 would stall the counter, so they run as /2.
   assign wdiv_c = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;

   always_comb begin
      wr_c = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         wr_c[i] = cfg_we && (cfg_addr == AW'(i));
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i]  = cnt_q[i];
         div_d[i]  = div_q[i];
         pdiv_d[i] = pdiv_q[i];
         pf_d[i]   = pf_q[i];
         cout_d[i] = 1'b0;
         tick_d[i] = 1'b0;
         // Disable, sync and period end all restart the count and commit a new divisor.
         if (!en[i] || sync || (cnt_q[i] == div_q[i] - CNT_W'(1))) begin
            cnt_d[i]  = '0;
            tick_d[i] = en[i] & ~sync;
            if (wr_c[i]) begin
               div_d[i] = wdiv_c;
            end else if (pf_q[i]) begin
               div_d[i] = pdiv_q[i];
            end
            pf_d[i] = 1'b0;
         end else begin
            cnt_d[i]  = cnt_q[i] + CNT_W'(1);
            cout_d[i] = (cnt_q[i] < (div_q[i] >> 1));
            if (wr_c[i]) begin
               pdiv_d[i] = wdiv_c;
               pf_d[i]   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]  <= '0;
            div_q[i]  <= rst_div(i);
            pdiv_q[i] <= '0;
         end
         pf_q   <= '0;
         cout_q <= '0;
         tick_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]  <= cnt_d[i];
            div_q[i]  <= div_d[i];
            pdiv_q[i] <= pdiv_d[i];
         end
         pf_q   <= pf_d;
         cout_q <= cout_d;
         tick_q <= tick_d;
      end
   end

   assign cout     = cout_q;
   assign tick     = tick_q;
   assign cfg_pend = pf_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: expected waveforms are queued per edge and
// compared after the edge with immediate assertions.
module tb_clk_div_bank;

   localparam int unsigned CH = 8;
   localparam int unsigned CW = 28;
   localparam int unsigned AW = 4;

   typedef struct packed {
      logic [CH-1:0] c;
      logic [CH-1:0] t;
      logic [CH-1:0] p;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [CW-1:0] cfg_div;
   logic [CH-1:0] en;
   logic          sync;
   logic [CH-1:0] cout;
   logic [CH-1:0] tick;
   logic [CH-1:0] cfg_pend;

   int            k;
   int            mdiv   [CH];
   int            mstart [CH];
   logic [CH-1:0] tick0;
   logic [CH-1:0] mpend;
   int            checks;
   int            errors;
   exp_t          sb_q [$];

   clk_div_bank #(.CHANNELS(CH), .CNT_W(CW), .AW(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_div  (cfg_div),
      .en       (en),
      .sync     (sync),
      .cout     (cout),
      .tick     (tick),
      .cfg_pend (cfg_pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s edge=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic model_reset();
      k = 0;
      for (int i = 0; i < CH; i++) begin
         mdiv[i]   = 2 << i;
         mstart[i] = 0;
      end
      tick0 = '0;
      mpend = '0;
   endtask

   // Channel ch switches to divisor d at the coming edge, which is a period boundary.
   task automatic set_div(input int ch, input int d);
      mdiv[ch]   = d;
      mstart[ch] = k + 1;
      tick0[ch]  = 1'b1;
   endtask

   task automatic cyc();
      exp_t e;
      exp_t g;
      int   m;
      k++;
      for (int i = 0; i < CH; i++) begin
         if (!en[i] || sync) begin
            mstart[i] = k;
            tick0[i]  = 1'b0;
         end
         m = k - mstart[i];
         if (m <= 0) begin
            e.c[i] = 1'b0;
            e.t[i] = tick0[i];
         end else begin
            e.c[i] = ((m - 1) % mdiv[i]) < (mdiv[i] / 2);
            e.t[i] = (m % mdiv[i]) == 0;
         end
      end
      e.p = mpend;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      g = sb_q.pop_front();
      chk("cout", cout, g.c);
      chk("tick", tick, g.t);
      chk("cfg_pend", cfg_pend, g.p);
   endtask

   task automatic wr(input int a, input int v);
      cfg_we   = 1'b1;
      cfg_addr = AW'(a);
      cfg_div  = CW'(v);
      cyc();
      cfg_we   = 1'b0;
   endtask

   task automatic do_sync();
      sync = 1'b1;
      cyc();
      sync = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      cfg_we   = 1'b0;
      cfg_addr = '0;
      cfg_div  = '0;
      en       = '1;
      sync     = 1'b0;
      checks   = 0;
      errors   = 0;
      model_reset();

      // Reset state and free-running reset divisors /2 .. /256.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cout", cout, 8'h00);
      chk("rst_tick", tick, 8'h00);
      chk("rst_pend", cfg_pend, 8'h00);
      @(negedge clk) rst_n = 1'b1;
      repeat (512) cyc();

      // Channel 0 reprogrammed to /5 mid-period.
      do_sync();
      mpend[0] = 1'b1;
      wr(0, 5);
      set_div(0, 5);
      mpend[0] = 1'b0;
      cyc();
      repeat (15) cyc();

      // Channel 2: last of two writes wins, then 0/1 clamp to /2.
      do_sync();
      mpend[2] = 1'b1;
      wr(2, 6);
      wr(2, 10);
      repeat (5) cyc();
      set_div(2, 10);
      mpend[2] = 1'b0;
      cyc();
      mpend[2] = 1'b1;
      wr(2, 0);
      wr(2, 1);
      repeat (7) cyc();
      set_div(2, 2);
      mpend[2] = 1'b0;
      cyc();
      repeat (10) cyc();

      // Out-of-range address, then channel 3 written exactly on its boundary.
      do_sync();
      wr(8, 3);
      repeat (14) cyc();
      set_div(3, 4);
      wr(3, 4);
      repeat (12) cyc();

      // Sync from mixed phases: all low, then all rise together.
      sync = 1'b1;
      cyc();
      sync = 1'b0;
      chk("sync_low", cout, 8'h00);
      cyc();
      chk("sync_rise", cout, 8'hFF);

      // Channel 1 disabled for 10 edges, with a direct write and a sync inside.
      en[1] = 1'b0;
      repeat (2) cyc();
      mdiv[1] = 3;
      wr(1, 3);
      repeat (2) cyc();
      do_sync();
      repeat (4) cyc();
      en[1] = 1'b1;
      cyc();
      chk("reen_cout1", {7'b0, cout[1]}, 8'h01);
      repeat (10) cyc();

      // Asynchronous reset with a divisor pending on channel 4.
      do_sync();
      mpend[4] = 1'b1;
      wr(4, 7);
      repeat (3) cyc();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_cout", cout, 8'h00);
      chk("arst_tick", tick, 8'h00);
      chk("arst_pend", cfg_pend, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      repeat (70) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of independent clock dividers. Each channel divides `clk` by a divisor that software can reprogram at runtime, and each has its own enable. Divisor changes are glitch-free: they are applied only at a period boundary. A global `sync` strobe realigns the phase of all channels. The bank sits next to the chip clock input and drives the registered divided-clock and tick outputs that other blocks use for blinking, sampling and strobing.

## Interface
Parameters:
- `CHANNELS`, default 8: number of divider channels, 1..16.
- `CNT_W`, default 28: counter and divisor width.
- `AW`, default 3: `cfg_addr` width; must satisfy 2^AW >= CHANNELS.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `cfg_we`  in  1  divisor write strobe, one cycle.
- `cfg_addr`  in  AW  channel index for the write.
- `cfg_div`  in  CNT_W  divisor value for the write.
- `en`  in  CHANNELS  per-channel enable, level-sensitive.
- `sync`  in  1  one-cycle strobe that realigns all channels.
- `cout`  out  CHANNELS  registered divided clocks.
- `tick`  out  CHANNELS  one-cycle pulse in the last cycle of each period.
- `cfg_pend`  out  CHANNELS  a written divisor is waiting for the next boundary.

## Operation
Per-channel state:
- `cnt[CNT_W]` counts 0..D-1.
- `D` is the active divisor; `P` is the pending divisor; `pf` is the pending flag.
- `cfg_pend[i] = pf[i]`.

Divisor rules:
- Effective divisor = max(written value, 2). Values 0 and 1 clamp to 2.
- Reset divisor of channel i = 2^(i+1), capped at 2^(CNT_W-1). At reset the bank therefore behaves as a /2, /4, ... /256 chain.

Each rising edge, per channel i, in priority order:
1. `!en[i]`: cnt<=0, cout<=0, tick<=0. Any write or pending value loads D directly and clears pf.
2. `sync`: cnt<=0, cout<=0, tick<=0. The write value if present, else P if pf set, loads D; pf<=0.
3. Boundary (cnt==D-1): cnt<=0, cout<=0, tick<=1. The write value if present, else P if pf set, loads D; pf<=0.
4. Otherwise: cnt<=cnt+1, cout<=(cnt < D/2), tick<=0. A write to i sets P and pf<=1.

Write handling:
- A write to an address >= CHANNELS is ignored.
- When several writes land before one boundary, the last one wins.

Waveform:
- cout is high for floor(D/2) cycles and low for ceil(D/2) cycles per period.
- For odd D the duty cycle is not 50%; this is intended.
- Period is exactly D cycles, measured between rising edges of cout.

## Timing
Reset (`rst_n` low) sets:
- cnt=0, cout=0, tick=0, pf=0.
- D = reset divisor for each channel.

Latency and period:
- First edge after reset or enable, or after a sync edge: cout rises 1 cycle later.
- tick coincides with the last low cycle of cout and precedes the cout rising edge by 1 cycle.
- A new divisor never truncates or stretches a period in progress, except through `en` low or `sync`.
- cfg_pend asserts 1 cycle after the write and clears on the boundary edge.

Reset and enable edge cases:
- Reset mid-period: outputs clear immediately (asynchronous); any pending divisor is lost.
- `sync` together with en low: the channel is held disabled (rule 1 wins).

## Test plan
- Reset release, en=all ones, no writes: channel 0 cout toggles every cycle (period 2); channel 7 period is 256 with 128 cycles high. tick[7] fires every 256 cycles.
- En=1 on channel 0; write cfg_div=5 to channel 0 mid-period: old period completes; from the following boundary cout is 2 high / 3 low, and cfg_pend[0] is 1 until that boundary.
- Write cfg_div=0 and then cfg_div=1 to channel 2: divisor clamps to 2. Two writes before one boundary (6 then 10): period becomes 10 and 6 is never observed.
- Write on the exact boundary cycle of channel 3 (D=16, cfg_div=4): the next period is 4 and cfg_pend[3] never asserts.
- Channels running with different phases, pulse `sync`: all cout go low for 1 cycle and then rise together. Also check `en[1]` low for 10 cycles: cout[1]=0 and tick[1]=0, and on re-enable cout[1] rises after 1 cycle.
- Assert rst_n low mid-period with a write pending on channel 4: outputs are 0 asynchronously, and after release channel 4 runs at reset divisor 32.
